// File: rtl/fft16_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft16_input_loader
// Brief    : Serial-to-parallel loader that gathers 16 complex samples into a
//            frame and presents all lanes at once to a radix-4 first stage.
//            Optional macro FFT16_LOADER_PINGPONG_EN selects a two-bank
//            ping-pong buffer; otherwise a single FILL/HOLD bank is used.
// Revision : 1.0 - initial release
// ============================================================================
module fft16_input_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sof,
    input  logic [15:0]  in_re,
    input  logic [15:0]  in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_re,
    output logic [255:0] out_im,
    output logic         frame_err
);

    localparam logic [3:0] LAST_IDX = 4'd15;

    logic [3:0] wr_idx;
    logic       write;
    logic       read;
    logic       complete;
    logic [3:0] lane;

    assign write    = in_valid & in_ready;
    assign read     = out_valid & out_ready;
    // A start-of-frame write always lands in lane 0, so it never completes a frame.
    assign lane     = in_sof ? 4'd0 : wr_idx;
    assign complete = write & ~in_sof & (wr_idx == LAST_IDX);

    // Write index tracking and truncated-frame error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx    <= 4'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= write & in_sof & (wr_idx != 4'd0);
            if (write) begin
                wr_idx <= in_sof ? 4'd1 : wr_idx + 4'd1;
            end
        end
    end

`ifdef FFT16_LOADER_PINGPONG_EN

    logic [15:0] bank_re [2][16];
    logic [15:0] bank_im [2][16];
    logic [1:0]  full;
    logic [1:0]  full_nxt;
    logic        fill_sel;
    logic        rd_sel;
    logic        rd_sel_nxt;

    // Next bank occupancy: a read frees the presented bank, a completion fills the other.
    always_comb begin
        full_nxt = full;
        if (read) begin
            full_nxt[rd_sel] = 1'b0;
        end
        if (complete) begin
            full_nxt[fill_sel] = 1'b1;
        end
        rd_sel_nxt = rd_sel ^ read;
    end

    // Bank bookkeeping; handshake outputs come straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 2'b00;
            fill_sel  <= 1'b0;
            rd_sel    <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            full      <= full_nxt;
            fill_sel  <= fill_sel ^ complete;
            rd_sel    <= rd_sel_nxt;
            out_valid <= full_nxt[rd_sel_nxt];
            in_ready  <= ~(&full_nxt);
        end
    end

    // Sample storage; the filling bank is never the presented full bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 16; k++) begin
                    bank_re[b][k] <= 16'd0;
                    bank_im[b][k] <= 16'd0;
                end
            end
        end else if (write) begin
            bank_re[fill_sel][lane] <= in_re;
            bank_im[fill_sel][lane] <= in_im;
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_lane
        assign out_re[16*k +: 16] = bank_re[rd_sel][k];
        assign out_im[16*k +: 16] = bank_im[rd_sel][k];
    end

`else

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] bank_re [16];
    logic [15:0] bank_im [16];

    // FILL accepts samples until completion; HOLD presents the frame until read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FILL;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    if (complete) begin
                        state     <= ST_HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (read) begin
                        state     <= ST_FILL;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_FILL;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sample storage for the single bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                bank_re[k] <= 16'd0;
                bank_im[k] <= 16'd0;
            end
        end else if (write) begin
            bank_re[lane] <= in_re;
            bank_im[lane] <= in_im;
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_lane
        assign out_re[16*k +: 16] = bank_re[k];
        assign out_im[16*k +: 16] = bank_im[k];
    end

`endif

endmodule
`default_nettype wire

// File: doc/fft16_input_loader.md
FFT16_INPUT_LOADER -- requirements
Module: fft16_input_loader

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  serial sample present.
REQ-004 SHALL have ports: in_ready  output  1  loader accepts sample this cycle.
REQ-005 SHALL have ports: in_sof  input  1  qualifies sample as index 0 of a frame.
REQ-006 SHALL have ports: in_re, in_im  input  16 each  two's-complement sample.
REQ-007 SHALL have ports: out_valid  output  1  complete 16-sample frame presented.
REQ-008 SHALL have ports: out_ready  input  1  downstream radix-4 first stage consumes frame.
REQ-009 SHALL have ports: out_re, out_im  output  256 each  lane k = bits [16k+15:16k] = sample k, k=0..15, feeding the stage's re_k/im_k.
REQ-010 SHALL have ports: frame_err  output  1  one-cycle pulse on truncated frame.

Function
REQ-011 SHALL accept a sample only on a cycle with in_valid=1 and in_ready=1 (a "write").
REQ-012 SHALL keep a 4-bit write index wr_idx; each write stores in_re/in_im at lane wr_idx of the filling bank, then wr_idx increments, wrapping 15->0.
REQ-013 SHALL, on a write with in_sof=1, store the sample at lane 0 and set wr_idx to 1, discarding any partial frame.
REQ-014 SHALL pulse frame_err for exactly one cycle, the cycle after a write with in_sof=1 occurring while wr_idx!=0; no pulse when wr_idx=0.
REQ-015 SHALL treat the write at wr_idx=15 as frame completion; the filling bank becomes FULL and out_valid rises the following cycle (latency 1 clock from last write).
REQ-016 SHALL hold out_re/out_im/out_valid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL release the presented bank on a cycle with out_valid=1 and out_ready=1 (a "read"); out_valid falls next cycle unless another bank is FULL.
REQ-018 SHALL pass data unmodified; no scaling, no sign extension, no reordering (natural order).
REQ-019 SHALL derive in_ready and out_valid from registered state only (no combinational path from out_ready or in_valid).
REQ-020 SHALL ignore in_re/in_im/in_sof when no write occurs.
REQ-021 SHALL, when a read and a frame completion occur on the same cycle, perform both; the newly completed frame is presented next cycle.

Reset
REQ-022 SHALL, while rst=1, force wr_idx=0, all banks EMPTY, out_valid=0, frame_err=0, in_ready=0; out_re/out_im=0.
REQ-023 SHALL raise in_ready the first clock edge after rst deasserts; reset mid-frame discards the partial frame with no frame_err.

Configuration
REQ-024 SHALL, with FFT16_LOADER_PINGPONG_EN defined, use two banks (A,B) filled alternately starting with A; in_ready=0 only when both banks FULL; frames are presented oldest first.
REQ-025 SHALL, without FFT16_LOADER_PINGPONG_EN, use one bank with states FILL->HOLD->FILL: FILL (in_ready=1, out_valid=0) goes to HOLD on completion; HOLD (in_ready=0, out_valid=1) returns to FILL on read.
REQ-026 SHALL, in both builds, give identical out_re/out_im contents per frame.

Verification
REQ-027 SHALL cover: rst then 16 writes re=k, im=-k with in_sof on first, out_ready=1 -> out_valid 1 clock after 16th write, lane k re=k, im=-k, out_valid low next cycle.
REQ-028 SHALL cover: 5 writes, then in_sof write re=0x7FFF, then 15 writes -> frame_err single pulse; lane 0 re=0x7FFF; no frame from truncated 5.
REQ-029 SHALL cover: out_ready=0, 40 consecutive in_valid cycles -> pingpong build: in_ready falls after 32 writes, two frames emitted in order; single-bank build: in_ready falls after 16 writes.
REQ-030 SHALL cover: pingpong, out_ready pulsed on the exact cycle bank B completes -> frame A consumed, frame B presented next cycle, no write lost.
REQ-031 SHALL cover: rst asserted after 9 writes, then full frame -> output equals the new frame only, frame_err never asserted.
REQ-032 SHALL cover: random in_valid/out_ready, 1000 frames, 0x8000/0x7FFF extremes -> scoreboard exact match, out stable whenever out_valid & !out_ready.
